// File: rtl/iic_pkg.sv
// Shared I2C target definitions: CPU register offsets, SCON bit positions, FSM encoding.
package iic_pkg;

  localparam int REG_SCON  = 0;
  localparam int REG_SADDR = 1;
  localparam int REG_STX   = 2;
  localparam int REG_SRX   = 3;

  localparam int SCON_EN        = 0;
  localparam int SCON_ADDRESSED = 1;
  localparam int SCON_RX_VALID  = 2;
  localparam int SCON_RW_DIR    = 3;
  localparam int SCON_OVERRUN   = 5;
  localparam int SCON_NACK      = 6;

  localparam logic [3:0] BYTE_BITS = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_RX_DATA  = 3'd3,
    ST_RX_ACK   = 3'd4,
    ST_TX_DATA  = 3'd5,
    ST_TX_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } iic_state_t;

endpackage

// File: rtl/iic_sync_filter.sv
// One bus line into the clk domain: 2-flop synchronizer reset to 1 (idle bus), 2 clk latency, no backpressure.
// IIC_SLAVE_GLITCH_FILTER_EN adds a registered 3-sample majority vote (+2 clk) that rejects 1-clk pulses.
module iic_sync_filter (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], din};
  end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       vote;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 2'b11;
      vote <= 1'b1;
    end else begin
      hist <= {hist[0], sync[1]};
      vote <= (sync[1] & hist[0]) | (sync[1] & hist[1]) | (hist[0] & hist[1]);
    end
  end

  assign dout = vote;
`else
  assign dout = sync[1];
`endif

endmodule

// File: rtl/iic_slave_top.sv
// I2C target with CPU registers SCON/SADDR/STX/SRX; dout valid 1 clk after rd_en, bus edges seen 3 clk late
// (+2 with IIC_SLAVE_GLITCH_FILTER_EN); no backpressure: a byte arriving while SRX is full is NACKed (overrun).
module iic_slave_top
  import iic_pkg::*;
#(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t
);

  localparam int DEC_W = OPT_MEM_ADDR_BITS + 1;
  localparam int DEC_HI = ADDR_LSB + DEC_W;

  logic             enable, overrun, nack, rx_valid, rw_dir, addressed;
  logic [6:0]       saddr;
  logic [7:0]       stx, srx, scon_val, rd_data;
  logic [DEC_W-1:0] reg_sel;
  logic             addr_hit;

  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  iic_state_t state, state_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       sda_low, sda_low_nxt, rw_nxt;
  logic       rx_store, set_ovr, set_nack;

  iic_sync_filter u_scl (.clk(clk), .reset(reset), .din(scl_i), .dout(scl_s));
  iic_sync_filter u_sda (.clk(clk), .reset(reset), .din(sda_i), .dout(sda_s));

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Open-drain: only ever pull low; reset releases the line without waiting for the flop.
  assign sda_o = 1'b0;
  assign sda_t = reset | ~sda_low;

  assign addressed = (state == ST_ADDR_ACK) || (state == ST_RX_DATA) || (state == ST_RX_ACK) ||
                     (state == ST_TX_DATA) || (state == ST_TX_ACK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      shreg   <= 8'd0;
      cnt     <= 4'd0;
      sda_low <= 1'b0;
      rw_dir  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      sda_low <= sda_low_nxt;
      rw_dir  <= rw_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    sda_low_nxt = sda_low;
    rw_nxt      = rw_dir;
    rx_store    = 1'b0;
    set_ovr     = 1'b0;
    set_nack    = 1'b0;
    if (!enable || stop_det) begin
      state_nxt   = ST_IDLE;
      sda_low_nxt = 1'b0;
    end else if (start_det) begin
      state_nxt   = ST_ADDR;
      cnt_nxt     = 4'd0;
      sda_low_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_IGNORE: ;
        ST_ADDR: begin
          if (scl_rise && cnt != BYTE_BITS) begin
            shreg_nxt = {shreg[6:0], sda_s};
            cnt_nxt   = cnt + 4'd1;
          end else if (scl_fall && cnt == BYTE_BITS) begin
            cnt_nxt = 4'd0;
            if (shreg[7:1] == saddr) begin
              state_nxt   = ST_ADDR_ACK;
              sda_low_nxt = 1'b1;
              rw_nxt      = shreg[0];
            end else begin
              state_nxt = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_nxt = 4'd0;
            if (rw_dir) begin
              state_nxt   = ST_TX_DATA;
              shreg_nxt   = stx;
              sda_low_nxt = ~stx[7];
            end else begin
              state_nxt   = ST_RX_DATA;
              sda_low_nxt = 1'b0;
            end
          end
        end
        ST_RX_DATA: begin
          if (scl_rise && cnt != BYTE_BITS) begin
            shreg_nxt = {shreg[6:0], sda_s};
            cnt_nxt   = cnt + 4'd1;
          end else if (scl_fall && cnt == BYTE_BITS) begin
            cnt_nxt   = 4'd0;
            state_nxt = ST_RX_ACK;
            if (!rx_valid) begin
              rx_store    = 1'b1;
              sda_low_nxt = 1'b1;
            end else begin
              set_ovr = 1'b1;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_low_nxt = 1'b0;
            state_nxt   = ST_RX_DATA;
          end
        end
        ST_TX_DATA: begin
          if (scl_rise && cnt != BYTE_BITS) begin
            cnt_nxt = cnt + 4'd1;
          end else if (scl_fall) begin
            // cnt==0 only after a reload from TX_ACK: present the MSB without shifting.
            if (cnt == BYTE_BITS) begin
              cnt_nxt     = 4'd0;
              sda_low_nxt = 1'b0;
              state_nxt   = ST_TX_ACK;
            end else if (cnt == 4'd0) begin
              sda_low_nxt = ~shreg[7];
            end else begin
              shreg_nxt   = {shreg[6:0], 1'b0};
              sda_low_nxt = ~shreg[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_nxt = ST_TX_DATA;
              shreg_nxt = stx;
              cnt_nxt   = 4'd0;
            end else begin
              set_nack  = 1'b1;
              state_nxt = ST_IGNORE;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Upper address bits must be zero so aliases above the register window are not decoded.
  assign reg_sel  = addr[ADDR_LSB +: DEC_W];
  assign addr_hit = (addr >> DEC_HI) == 8'd0;

  always_comb begin
    scon_val                 = 8'd0;
    scon_val[SCON_EN]        = enable;
    scon_val[SCON_ADDRESSED] = addressed;
    scon_val[SCON_RX_VALID]  = rx_valid;
    scon_val[SCON_RW_DIR]    = rw_dir;
    scon_val[SCON_OVERRUN]   = overrun;
    scon_val[SCON_NACK]      = nack;
    rd_data = 8'd0;
    if (addr_hit) begin
      if (reg_sel == DEC_W'(REG_SCON))       rd_data = scon_val;
      else if (reg_sel == DEC_W'(REG_SADDR)) rd_data = {1'b0, saddr};
      else if (reg_sel == DEC_W'(REG_STX))   rd_data = stx;
      else if (reg_sel == DEC_W'(REG_SRX))   rd_data = srx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable   <= 1'b0;
      overrun  <= 1'b0;
      nack     <= 1'b0;
      rx_valid <= 1'b0;
      saddr    <= 7'd0;
      stx      <= 8'd0;
      srx      <= 8'd0;
      dout     <= 8'd0;
    end else begin
      if (wr_en) begin
        if (addr_hit && reg_sel == DEC_W'(REG_SCON)) begin
          enable  <= din[SCON_EN];
          overrun <= 1'b0;
          nack    <= 1'b0;
        end else if (addr_hit && reg_sel == DEC_W'(REG_SADDR)) begin
          saddr <= din[6:0];
        end else if (addr_hit && reg_sel == DEC_W'(REG_STX)) begin
          stx <= din;
        end
      end else if (rd_en) begin
        dout <= rd_data;
        if (addr_hit && reg_sel == DEC_W'(REG_SRX)) rx_valid <= 1'b0;
      end
      // Bus-side events land after CPU clears so a simultaneous flag event is not lost.
      if (rx_store) begin
        srx      <= shreg;
        rx_valid <= 1'b1;
      end
      if (set_ovr)  overrun <= 1'b1;
      if (set_nack) nack    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iic_slave_top.sv
// Directed bench for iic_slave_top: bit-banged I2C master on a wired-AND SDA plus CPU register accesses.
// Glitch expectations depend on IIC_SLAVE_GLITCH_FILTER_EN, matching the build of the design.
module tb_iic_slave_top;
  import iic_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset, wr_en, rd_en, scl_m, sda_m, sda_o, sda_t, sda_bus;
  logic [7:0] addr, din, dout;
  int         n_vec = 0;
  int         n_err = 0;
  int         low_cnt = 0;

  iic_slave_top dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout),
    .wr_en(wr_en), .rd_en(rd_en), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_o(sda_o), .sda_t(sda_t)
  );

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_t | sda_o);

  always @(negedge clk) if (!sda_t) low_cnt++;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = {6'd0, a}; din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = {6'd0, a}; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    d = dout;
  endtask

  task automatic bus_start;
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic put_bit(input logic b, input bit glitch);
    sda_m = b;
    if (glitch) begin
      tick(3); scl_m = 1'b1; tick(1); scl_m = 1'b0; tick(Q - 4);
    end else begin
      tick(Q);
    end
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic put_byte(input logic [7:0] v, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(v[i], (7 - i) == glitch_bit);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      v[i] = b;
    end
    put_bit(ack, 1'b0);
  endtask

  initial begin
    logic [7:0] rd, rx, v;
    logic       ack;
    int         low0;
    logic [7:0] exp_srx;
    logic       exp_ack;

    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 8'd0; din = 8'd0;
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_val("rst_sda_t", 8'(sda_t), 8'd1);
    check_val("rst_sda_o", 8'(sda_o), 8'd0);
    check_val("rst_dout", dout, 8'h00);
    for (int r = 0; r < 4; r++) begin
      cpu_rd(2'(r), rd);
      check_val($sformatf("rst_reg%0d", r), rd, 8'h00);
    end

    cpu_wr(2'd1, 8'h3C);
    cpu_wr(2'd0, 8'h01);
    cpu_rd(2'd1, rd); check_val("saddr_rb", rd, 8'h3C);
    cpu_rd(2'd0, rd); check_val("scon_rb", rd, 8'h01);

    @(negedge clk);
    addr = 8'd2; din = 8'h5A; wr_en = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    check_val("wr_prio_dout", dout, 8'h01);
    cpu_rd(2'd2, rd); check_val("stx_rb", rd, 8'h5A);

    // Master write 0x78, 0xA5
    bus_start;
    put_byte(8'h78, -1, ack); check_val("w_addr_ack", 8'(ack), 8'd0);
    put_byte(8'hA5, -1, ack); check_val("w_data_ack", 8'(ack), 8'd0);
    cpu_rd(2'd0, rd); check_val("w_scon_mid", rd, 8'h07);
    bus_stop;
    cpu_rd(2'd0, rd); check_val("w_scon_end", rd, 8'h05);
    cpu_rd(2'd3, rd); check_val("w_srx", rd, 8'hA5);
    cpu_rd(2'd0, rd); check_val("w_rxv_clr", rd, 8'h01);

    // Address mismatch
    low0 = low_cnt;
    bus_start;
    put_byte(8'h52, -1, ack); check_val("mm_ack", 8'(ack), 8'd1);
    check_val("mm_no_drive", 8'(low_cnt - low0), 8'd0);
    check_val("mm_state", 8'(dut.state), 8'(ST_IGNORE));
    cpu_rd(2'd0, rd); check_val("mm_scon", rd, 8'h01);
    bus_stop;
    check_val("mm_idle", 8'(dut.state), 8'(ST_IDLE));

    // Overrun: second byte while SRX unread
    bus_start;
    put_byte(8'h78, -1, ack); check_val("ov_addr_ack", 8'(ack), 8'd0);
    put_byte(8'h11, -1, ack); check_val("ov_b1_ack", 8'(ack), 8'd0);
    put_byte(8'h22, -1, ack); check_val("ov_b2_nack", 8'(ack), 8'd1);
    bus_stop;
    cpu_rd(2'd0, rd); check_val("ov_scon", rd, 8'h25);
    cpu_rd(2'd3, rd); check_val("ov_srx", rd, 8'h11);
    cpu_wr(2'd0, 8'h01);
    cpu_rd(2'd0, rd); check_val("ov_clr", rd, 8'h01);

    // Master read of two bytes, ACK then NACK
    cpu_wr(2'd2, 8'hC3);
    bus_start;
    put_byte(8'h79, -1, ack); check_val("r_addr_ack", 8'(ack), 8'd0);
    get_byte(1'b0, rx); check_val("r_byte1", rx, 8'hC3);
    get_byte(1'b1, rx); check_val("r_byte2", rx, 8'hC3);
    cpu_rd(2'd0, rd); check_val("r_scon_nack", rd, 8'h49);
    bus_stop;
    check_val("r_idle", 8'(dut.state), 8'(ST_IDLE));
    cpu_wr(2'd0, 8'h01);
    cpu_rd(2'd0, rd); check_val("r_nack_clr", rd, 8'h09);

    // Reset while the address ACK is being driven
    v = 8'h78;
    bus_start;
    for (int i = 7; i >= 0; i--) put_bit(v[i], 1'b0);
    sda_m = 1'b1; tick(Q);
    check_val("ra_ack_drv", 8'(sda_t), 8'd0);
    reset = 1'b1; tick(1);
    check_val("ra_release", 8'(sda_t), 8'd1);
    reset = 1'b0;
    check_val("ra_state", 8'(dut.state), 8'(ST_IDLE));
    for (int r = 0; r < 4; r++) begin
      cpu_rd(2'(r), rd);
      check_val($sformatf("ra_reg%0d", r), rd, 8'h00);
    end
    bus_stop;

    // SCL glitch during the first data bit of 0x5A
`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    exp_ack = 1'b0; exp_srx = 8'h5A;
`else
    // Unfiltered: the glitch shifts an extra 0, the byte closes one bit early as 0x2D and the ACK slot is missed.
    exp_ack = 1'b1; exp_srx = 8'h2D;
`endif
    cpu_wr(2'd1, 8'h3C);
    cpu_wr(2'd0, 8'h01);
    bus_start;
    put_byte(8'h78, -1, ack); check_val("g_addr_ack", 8'(ack), 8'd0);
    put_byte(8'h5A, 0, ack); check_val("g_data_ack", 8'(ack), 8'(exp_ack));
    bus_stop;
    cpu_rd(2'd3, rd); check_val("g_srx", rd, exp_srx);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iic_slave_top.md
IIC_SLAVE_TOP -- requirements
Module: iic_slave_top

Interface
REQ-001 SHALL have parameter ADDR_LSB, default 0, LSB of the CPU address field used for register decode.
REQ-002 SHALL have parameter OPT_MEM_ADDR_BITS, default 1, MSB offset of the register decode field (4 registers).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports addr, din  input  8 each  CPU register address and write data.
REQ-006 SHALL have port dout  output  8  CPU read data, registered.
REQ-007 SHALL have ports wr_en, rd_en  input  1 each  CPU write and read strobes, one clk per access.
REQ-008 SHALL have port scl_i  input  1  bus SCL, asynchronous to clk.
REQ-009 SHALL have port sda_i  input  1  bus SDA, asynchronous to clk.
REQ-010 SHALL have ports sda_o  output  1  (constant 0) and sda_t  output  1  (1 = release, 0 = drive low); open-drain only.

Function
REQ-011 SHALL decode registers: 0 SCON, 1 SADDR ([6:0] own address), 2 STX (byte to send), 3 SRX (read-only received byte).
REQ-012 SCON bits SHALL be: [0] enable (rw), [1] addressed (ro), [2] rx_valid (ro), [3] rw_dir (ro, 1 = master read), [5] overrun (sticky), [6] master NACK seen (sticky); a CPU write to SCON SHALL clear [5] and [6].
REQ-013 wr_en SHALL take priority over rd_en in the same cycle; dout SHALL update one clk after rd_en; reading SRX SHALL clear rx_valid the following cycle.
REQ-014 scl_i and sda_i SHALL pass through a 2-flop synchronizer; edge detection SHALL use synchronized values (sync-to-detect latency 3 clk).
REQ-015 START SHALL be SDA falling while SCL high; STOP SHALL be SDA rising while SCL high; both SHALL be detected in every state, including repeated START.
REQ-016 FSM states SHALL be IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, IGNORE.
REQ-017 START (enable = 1) -> ADDR; STOP -> IDLE from any state; enable = 0 -> IDLE with sda_t = 1.
REQ-018 ADDR SHALL shift 8 bits MSB first on SCL rising; on match of [7:1] with SADDR -> ADDR_ACK, else -> IGNORE until START/STOP.
REQ-019 ACK SHALL assert sda_t = 0 at the SCL falling edge after bit 8 and release at the following SCL falling edge.
REQ-020 After ADDR_ACK: R/W = 0 -> RX_DATA; R/W = 1 -> TX_DATA with STX loaded into shift register and MSB driven at that SCL falling edge.
REQ-021 RX_DATA: after 8 bits, if rx_valid = 0, SHALL copy byte to SRX, set rx_valid, ACK; if rx_valid = 1, SHALL NACK, discard byte, set overrun.
REQ-022 TX_DATA SHALL change SDA only on SCL falling edges; a 1 bit SHALL be sda_t = 1; after bit 8 SHALL release SDA for TX_ACK.
REQ-023 TX_ACK SHALL sample SDA on the 9th SCL rising: 0 -> reload STX, TX_DATA; 1 -> set NACK flag, IGNORE.
REQ-024 addressed SHALL be 1 from ADDR_ACK until STOP, START, or leaving to IDLE/IGNORE.

Reset
REQ-025 reset SHALL set all registers, dout and flags to 0, state to IDLE, sda_t = 1, synchronizers to 1 (bus idle).
REQ-026 reset mid-transfer SHALL release SDA in the same cycle reset is sampled.

Configuration
REQ-027 With IIC_SLAVE_GLITCH_FILTER_EN defined, synchronized SCL and SDA SHALL each pass a 3-sample majority filter (+2 clk latency); without it, synchronized signals SHALL feed edge detection directly.

Structure
REQ-028 Register offsets, SCON bit indices and FSM state encodings SHALL live in shared package iic_pkg.
REQ-029 Synchronizer plus optional filter SHALL be sub-module iic_sync_filter, instantiated once each for SCL and SDA.

Verification
REQ-030 SADDR=0x3C, master writes 0x78, 0xA5 -> address ACK, SRX=0xA5, rx_valid=1, rw_dir=0.
REQ-031 SADDR=0x3C, master sends 0x52 -> no ACK (sda_t stays 1), state IGNORE, addressed=0.
REQ-032 STX=0xC3, master sends 0x79 then reads 2 bytes ACK/NACK -> bus sees 0xC3 twice, NACK flag set, IDLE after STOP.
REQ-033 Two written bytes 0x11, 0x22 without reading SRX -> 2nd byte NACKed, SRX=0x11, overrun=1; SCON write clears overrun.
REQ-034 reset asserted during ACK bit -> sda_t=1 next cycle, all registers 0.
REQ-035 With IIC_SLAVE_GLITCH_FILTER_EN, 1-clk SCL glitch during data bit -> no extra bit shifted; without it, bench documents the corruption.
